// File: rtl/regfile_pkg.sv
// Shared types and defaults for the dual-bank register file with scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned NREGS_DEF   = 32;
  localparam int unsigned NRD_DEF     = 2;
  localparam int unsigned AW_DEF      = $clog2(NREGS_DEF);
  localparam int unsigned SP_INIT_DEF = 1048572;
  localparam int unsigned GP_INIT_DEF = 131072;

  typedef enum logic {
    BANK_INT = 1'b0,
    BANK_FP  = 1'b1
  } bank_e;

  typedef struct packed {
    logic                  valid;
    bank_e                 isf;
    logic [AW_DEF-1:0]     addr;
    logic [XLEN_DEF-1:0]   data;
  } wb_t;

  function automatic logic in_range(int unsigned addr, int unsigned nregs);
    return addr < nregs;
  endfunction

  // Integer x0 is hardwired: never written, never tracked.
  function automatic logic is_zero_reg(bank_e bank, int unsigned addr);
    return (bank == BANK_INT) && (addr == 0);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, issue and writeback bus between issue/execute stages and regfile_sb.
interface regfile_sb_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2
);
  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD-1:0]      rd_isf;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                iss_isf;
  logic                iss_stall;
  logic                wb0_valid;
  logic [AW-1:0]       wb0_addr;
  logic                wb0_isf;
  logic [XLEN-1:0]     wb0_data;
  logic                wb1_valid;
  logic [AW-1:0]       wb1_addr;
  logic                wb1_isf;
  logic [XLEN-1:0]     wb1_data;
  logic                flush;
  logic                err;

  modport master (
    output rd_addr, rd_isf, iss_valid, iss_addr, iss_isf,
    output wb0_valid, wb0_addr, wb0_isf, wb0_data,
    output wb1_valid, wb1_addr, wb1_isf, wb1_data, flush,
    input  rd_data, rd_busy, iss_stall, err
  );

  modport slave (
    input  rd_addr, rd_isf, iss_valid, iss_addr, iss_isf,
    input  wb0_valid, wb0_addr, wb0_isf, wb0_data,
    input  wb1_valid, wb1_addr, wb1_isf, wb1_data, flush,
    output rd_data, rd_busy, iss_stall, err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register in each bank, WAW stall,
// and a sticky error for colliding writebacks.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = NRD_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr_i,
  input  logic [NRD-1:0]    rd_isf_i,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic              iss_isf_i,
  output logic              iss_stall_o,
  input  logic              wb0_valid_i,
  input  logic              wb0_isf_i,
  input  logic [AW-1:0]     wb0_addr_i,
  input  logic              wb1_valid_i,
  input  logic              wb1_isf_i,
  input  logic [AW-1:0]     wb1_addr_i,
  input  logic              flush_i,
  output logic              err_o
);

  logic [NREGS-1:0] busy_q [2];
  logic [NREGS-1:0] busy_d [2];
  logic             err_q, err_d;

  function automatic logic tracked(logic isf, logic [AW-1:0] a);
    return in_range(32'(a), NREGS) && !is_zero_reg(bank_e'(isf), 32'(a));
  endfunction

  // Flush wins over stale busy state, so the same-cycle issue is never stalled.
  assign iss_stall_o = iss_valid_i && !flush_i && tracked(iss_isf_i, iss_addr_i) &&
                       busy_q[iss_isf_i][iss_addr_i];

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a            = rd_addr_i[i*AW +: AW];
    assign rd_busy_o[i] = tracked(rd_isf_i[i], a) && busy_q[rd_isf_i[i]][a];
  end

  // Order matters: flush, then writeback clears, then issue set.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (flush_i) begin
      busy_d[0] = '0;
      busy_d[1] = '0;
    end
    if (wb0_valid_i && tracked(wb0_isf_i, wb0_addr_i)) busy_d[wb0_isf_i][wb0_addr_i] = 1'b0;
    if (wb1_valid_i && tracked(wb1_isf_i, wb1_addr_i)) busy_d[wb1_isf_i][wb1_addr_i] = 1'b0;
    if (iss_valid_i && !iss_stall_o && tracked(iss_isf_i, iss_addr_i))
      busy_d[iss_isf_i][iss_addr_i] = 1'b1;
    if (wb0_valid_i && wb1_valid_i && (wb0_isf_i == wb1_isf_i) &&
        (wb0_addr_i == wb1_addr_i) && tracked(wb0_isf_i, wb0_addr_i))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q[0] <= '0;
      busy_q[1] <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Dual-bank (integer/FP) register file with two writeback ports and scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned NRD     = NRD_DEF,
  parameter int unsigned SP_INIT = SP_INIT_DEF,
  parameter int unsigned GP_INIT = GP_INIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0] int_q [NREGS];
  logic [XLEN-1:0] int_d [NREGS];
  logic [XLEN-1:0] fp_q  [NREGS];
  logic [XLEN-1:0] fp_d  [NREGS];
  wb_t             wb_s  [2];

  assign wb_s[0] = '{valid: bus.wb0_valid, isf: bank_e'(bus.wb0_isf),
                     addr: AW_DEF'(bus.wb0_addr), data: XLEN_DEF'(bus.wb0_data)};
  assign wb_s[1] = '{valid: bus.wb1_valid, isf: bank_e'(bus.wb1_isf),
                     addr: AW_DEF'(bus.wb1_addr), data: XLEN_DEF'(bus.wb1_data)};

  function automatic logic wr_ok(wb_t w);
    return w.valid && in_range(32'(w.addr), NREGS) && !is_zero_reg(w.isf, 32'(w.addr));
  endfunction

  // wb1 applied first so wb0 wins a same-register collision.
  always_comb begin
    int_d = int_q;
    fp_d  = fp_q;
    for (int p = 1; p >= 0; p--) begin
      if (wr_ok(wb_s[p])) begin
        if (wb_s[p].isf == BANK_FP) fp_d[AW'(wb_s[p].addr)]  = XLEN'(wb_s[p].data);
        else                        int_d[AW'(wb_s[p].addr)] = XLEN'(wb_s[p].data);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        int_q[r] <= '0;
        fp_q[r]  <= '0;
      end
      int_q[2] <= XLEN'(SP_INIT);
      int_q[3] <= XLEN'(GP_INIT);
    end else begin
      int_q <= int_d;
      fp_q  <= fp_d;
    end
  end

  logic [NRD-1:0] sb_busy;

  regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD), .AW(AW)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_i   (bus.rd_addr),
    .rd_isf_i    (bus.rd_isf),
    .rd_busy_o   (sb_busy),
    .iss_valid_i (bus.iss_valid),
    .iss_addr_i  (bus.iss_addr),
    .iss_isf_i   (bus.iss_isf),
    .iss_stall_o (bus.iss_stall),
    .wb0_valid_i (bus.wb0_valid),
    .wb0_isf_i   (bus.wb0_isf),
    .wb0_addr_i  (bus.wb0_addr),
    .wb1_valid_i (bus.wb1_valid),
    .wb1_isf_i   (bus.wb1_isf),
    .wb1_addr_i  (bus.wb1_addr),
    .flush_i     (bus.flush),
    .err_o       (bus.err)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic            f;
    logic [XLEN-1:0] stored;
    assign a      = bus.rd_addr[i*AW +: AW];
    assign f      = bus.rd_isf[i];
    assign stored = !in_range(32'(a), NREGS) ? '0 : (f ? fp_q[a] : int_q[a]);
`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1;
    assign hit0 = !rst && wr_ok(wb_s[0]) && (wb_s[0].isf == bank_e'(f)) && (AW'(wb_s[0].addr) == a);
    assign hit1 = !rst && wr_ok(wb_s[1]) && (wb_s[1].isf == bank_e'(f)) && (AW'(wb_s[1].addr) == a);
    assign bus.rd_data[i*XLEN +: XLEN] = hit0 ? XLEN'(wb_s[0].data) :
                                         hit1 ? XLEN'(wb_s[1].data) : stored;
    assign bus.rd_busy[i] = sb_busy[i] && !(hit0 || hit1);
`else
    assign bus.rd_data[i*XLEN +: XLEN] = stored;
    assign bus.rd_busy[i] = sb_busy[i];
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed table, hand sequences, random vs model.
module tb_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam logic [31:0] SP    = 32'd1048572;
  localparam logic [31:0] GP    = 32'd131072;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();
  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int unsigned w0v, w0f, w0a, w0d;
    int unsigned w1v, w1f, w1a, w1d;
    int unsigned iv, isf, ia, fl;
    int unsigned r0f, r0a, r1f, r1a;
    int unsigned e0, e1, eb, es, ee;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_int [32];
  logic [31:0] m_fp  [32];
  bit          m_bi  [32];
  bit          m_bf  [32];
  bit          m_err;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.wb0_valid = 1'(v.w0v); bus.wb0_isf = 1'(v.w0f); bus.wb0_addr = 5'(v.w0a); bus.wb0_data = 32'(v.w0d);
    bus.wb1_valid = 1'(v.w1v); bus.wb1_isf = 1'(v.w1f); bus.wb1_addr = 5'(v.w1a); bus.wb1_data = 32'(v.w1d);
    bus.iss_valid = 1'(v.iv);  bus.iss_isf = 1'(v.isf); bus.iss_addr = 5'(v.ia);
    bus.flush     = 1'(v.fl);
    bus.rd_addr   = {5'(v.r1a), 5'(v.r0a)};
    bus.rd_isf    = {1'(v.r1f), 1'(v.r0f)};
  endtask

  // Drive on the falling edge, sample 1 ns later, then let the rising edge commit.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, " rd0"},   bus.rd_data[31:0],  32'(v.e0));
    chk({tag, " rd1"},   bus.rd_data[63:32], 32'(v.e1));
    chk({tag, " busy"},  32'(bus.rd_busy),   32'(v.eb));
    chk({tag, " stall"}, 32'(bus.iss_stall), 32'(v.es));
    chk({tag, " err"},   32'(bus.err),       32'(v.ee));
    @(posedge clk);
  endtask

  task automatic do_reset();
    vec_t z = '{default: 0};
    @(negedge clk);
    drive(z);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      m_int[r] = '0; m_fp[r] = '0; m_bi[r] = 1'b0; m_bf[r] = 1'b0;
    end
    m_int[2] = SP;
    m_int[3] = GP;
    m_err    = 1'b0;
  endtask

  function automatic bit is_x0(int unsigned f, int unsigned a);
    return (f == 0) && (a == 0);
  endfunction

  function automatic void model_read(input vec_t v, input int unsigned f, input int unsigned a,
                                     output int unsigned d, output int unsigned b);
    d = (f != 0) ? m_fp[a] : m_int[a];
    b = (f != 0) ? m_bf[a] : m_bi[a];
`ifdef REGFILE_BYPASS_EN
    if (v.w0v != 0 && v.w0f == f && v.w0a == a && !is_x0(f, a)) begin
      d = v.w0d; b = 0;
    end else if (v.w1v != 0 && v.w1f == f && v.w1a == a && !is_x0(f, a)) begin
      d = v.w1d; b = 0;
    end
`endif
  endfunction

  function automatic int unsigned model_stall(input vec_t v);
    if (v.iv == 0 || v.fl != 0 || is_x0(v.isf, v.ia)) return 0;
    return (v.isf != 0) ? 32'(m_bf[v.ia]) : 32'(m_bi[v.ia]);
  endfunction

  function automatic vec_t model_expect(input vec_t v);
    vec_t o = v;
    int unsigned b0, b1;
    model_read(v, v.r0f, v.r0a, o.e0, b0);
    model_read(v, v.r1f, v.r1a, o.e1, b1);
    o.eb = (b1 << 1) | b0;
    o.es = model_stall(v);
    o.ee = 32'(m_err);
    return o;
  endfunction

  function automatic void model_write(input int unsigned f, input int unsigned a, input int unsigned d);
    if (is_x0(f, a)) return;
    if (f != 0) begin m_fp[a] = d; m_bf[a] = 1'b0; end
    else        begin m_int[a] = d; m_bi[a] = 1'b0; end
  endfunction

  function automatic void model_step(input vec_t v);
    int unsigned st = model_stall(v);
    if (v.w0v != 0 && v.w1v != 0 && v.w0f == v.w1f && v.w0a == v.w1a && !is_x0(v.w0f, v.w0a))
      m_err = 1'b1;
    if (v.fl != 0)
      for (int r = 0; r < 32; r++) begin m_bi[r] = 1'b0; m_bf[r] = 1'b0; end
    if (v.w1v != 0) model_write(v.w1f, v.w1a, v.w1d);
    if (v.w0v != 0) model_write(v.w0f, v.w0a, v.w0d);
    if (v.iv != 0 && st == 0 && !is_x0(v.isf, v.ia)) begin
      if (v.isf != 0) m_bf[v.ia] = 1'b1;
      else            m_bi[v.ia] = 1'b1;
    end
  endfunction

  initial begin
    vec_t v;
    // w0v w0f w0a w0d | w1v w1f w1a w1d | iv isf ia fl | r0f r0a r1f r1a | e0 e1 eb es ee
    tbl[0]  = '{0,0,0,0,            0,0,0,0,            0,0,0,0, 0,2,0,3, SP,GP,0,0,0};
    tbl[1]  = '{0,0,0,0,            0,0,0,0,            0,0,0,0, 0,5,1,7, 0,0,0,0,0};
    tbl[2]  = '{1,0,0,32'hDEADBEEF, 0,0,0,0,            0,0,0,0, 0,0,0,2, 0,SP,0,0,0};
    tbl[3]  = '{0,0,0,0,            0,0,0,0,            1,0,0,0, 0,0,0,0, 0,0,0,0,0};
    tbl[4]  = '{0,0,0,0,            0,0,0,0,            0,0,0,0, 0,0,0,0, 0,0,0,0,0};
    tbl[5]  = '{0,0,0,0,            0,0,0,0,            1,1,3,0, 1,3,1,3, 0,0,0,0,0};
    tbl[6]  = '{0,0,0,0,            0,0,0,0,            1,1,3,0, 1,3,0,0, 0,0,1,1,0};
    tbl[7]  = '{0,0,0,0,            1,1,3,32'h3F800000, 0,0,0,0, 0,2,0,3, SP,GP,0,0,0};
    tbl[8]  = '{0,0,0,0,            0,0,0,0,            0,0,0,0, 1,3,1,3, 32'h3F800000,32'h3F800000,0,0,0};
    tbl[9]  = '{1,0,9,1,            1,0,9,2,            0,0,0,0, 0,2,0,3, SP,GP,0,0,0};
    tbl[10] = '{0,0,0,0,            0,0,0,0,            0,0,0,0, 0,9,0,9, 1,1,0,0,1};
    tbl[11] = '{0,0,0,0,            0,0,0,0,            1,0,4,0, 0,4,0,6, 0,0,0,0,1};
    tbl[12] = '{0,0,0,0,            0,0,0,0,            1,0,6,0, 0,4,0,6, 0,0,1,0,1};
    tbl[13] = '{0,0,0,0,            0,0,0,0,            1,0,4,1, 0,4,0,6, 0,0,3,0,1};
    tbl[14] = '{0,0,0,0,            0,0,0,0,            0,0,0,0, 0,4,0,6, 0,0,1,0,1};
    tbl[15] = '{0,0,0,0,            0,0,0,0,            1,0,4,0, 0,4,0,6, 0,0,1,1,1};
    tbl[16] = '{1,0,5,32'h77,       0,0,0,0,            1,0,5,0, 0,4,0,6, 0,0,1,0,1};
    tbl[17] = '{0,0,0,0,            0,0,0,0,            0,0,0,0, 0,5,0,5, 32'h77,32'h77,3,0,1};

    do_reset();
    for (int i = 0; i < 18; i++) run_vec(tbl[i], $sformatf("row%0d", i));

    // Reset clears the sticky error and the collided register.
    do_reset();
    run_vec('{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,9,0,2, 0,SP,0,0,0}, "post_rst");

    // Same-cycle read of a writeback, with and without forwarding.
    v = '{1,0,7,32'h55, 0,0,0,0, 0,0,0,0, 0,7,0,7, 0,0,0,0,0};
`ifdef REGFILE_BYPASS_EN
    v.e0 = 32'h55; v.e1 = 32'h55;
`endif
    run_vec(v, "byp_data");
    run_vec('{0,0,0,0, 0,0,0,0, 1,0,7,0, 0,7,0,7, 32'h55,32'h55,0,0,0}, "byp_next");
    v = '{1,0,7,32'h66, 0,0,0,0, 0,0,0,0, 0,7,0,2, 32'h55,SP,1,0,0};
`ifdef REGFILE_BYPASS_EN
    v.e0 = 32'h66; v.eb = 0;
`endif
    run_vec(v, "byp_busy");
    run_vec('{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,7,0,7, 32'h66,32'h66,0,0,0}, "byp_after");

    // Random traffic on a narrow address window to provoke hazards and collisions.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v.w0v = $urandom_range(0, 1); v.w0f = $urandom_range(0, 1); v.w0a = $urandom_range(0, 7); v.w0d = $urandom;
      v.w1v = $urandom_range(0, 1); v.w1f = $urandom_range(0, 1); v.w1a = $urandom_range(0, 7); v.w1d = $urandom;
      v.iv  = $urandom_range(0, 1); v.isf = $urandom_range(0, 1); v.ia  = $urandom_range(0, 7);
      v.fl  = ($urandom_range(0, 15) == 0) ? 1 : 0;
      v.r0f = $urandom_range(0, 1); v.r0a = $urandom_range(0, 7);
      v.r1f = $urandom_range(0, 1); v.r1a = $urandom_range(0, 7);
      v = model_expect(v);
      run_vec(v, $sformatf("rnd%0d", n));
      model_step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
